dmem_port_arbiter: RTL and testbench

//  Shares the single MMU data-memory port between the core load/store unit (C) and the

---
 rtl/dmem_port_arbiter_if.sv | 55 +++++
 rtl/dmem_port_arbiter.sv | 108 ++++++++++
 tb/tb_dmem_port_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_port_arbiter_if.sv
// Bundle of the core/debug request ports, the debug halt handshake and the MMU data port.
// The arbiter takes the slave view; requesters and the MMU model take the master view.
interface dmem_port_arbiter_if;
    logic        c_req;
    logic        c_we;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic [3:0]  c_be;
    logic        c_signed;
    logic        c_gnt;
    logic        c_rvalid;
    logic [31:0] c_rdata;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic        d_signed;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;

    logic        dbg_halt;
    logic        dbg_halt_ack;

    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_di;
    logic [3:0]  dm_be;
    logic        dm_signed;
    logic [31:0] dm_do;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata, c_be, c_signed,
        output c_gnt, c_rvalid, c_rdata,
        input  d_req, d_we, d_addr, d_wdata, d_be, d_signed,
        output d_gnt, d_rvalid, d_rdata,
        input  dbg_halt,
        output dbg_halt_ack,
        output dm_we, dm_addr, dm_di, dm_be, dm_signed,
        input  dm_do
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata, c_be, c_signed,
        input  c_gnt, c_rvalid, c_rdata,
        output d_req, d_we, d_addr, d_wdata, d_be, d_signed,
        input  d_gnt, d_rvalid, d_rdata,
        output dbg_halt,
        input  dbg_halt_ack,
        input  dm_we, dm_addr, dm_di, dm_be, dm_signed,
        output dm_do
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares one MMU data port between the core (C) and the debug/boot loader (D),
// with starvation override for D, read-data return routing and a debug halt handshake.
module dmem_port_arbiter #(
    parameter int MAX_WAIT = 4,
    parameter int WAIT_W   = 3
) (
    input  logic                  clk,
    input  logic                  resetb,
    dmem_port_arbiter_if.slave    bus
);
    typedef enum logic [1:0] {ARB, DRAIN, HALT} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_C, OWN_D} owner_t;

    state_t              state;
    state_t              state_nxt;
    owner_t              rd_owner;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                halt_ack;
    logic                c_gnt;
    logic                d_gnt;
    logic                d_starved;

    assign d_starved = (wait_cnt == WAIT_W'(MAX_WAIT));

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        c_gnt     = 1'b0;
        d_gnt     = 1'b0;
        state_nxt = state;
        case (state)
            ARB: begin
                if (bus.c_req && !(bus.d_req && d_starved)) begin
                    c_gnt = 1'b1;
                end else if (bus.d_req) begin
                    d_gnt = 1'b1;
                end
                state_nxt = bus.dbg_halt ? DRAIN : ARB;
            end
            DRAIN: state_nxt = bus.dbg_halt ? HALT : ARB;
            HALT: begin
                d_gnt     = bus.d_req;
                state_nxt = bus.dbg_halt ? HALT : ARB;
            end
            default: state_nxt = ARB;
        endcase
        // Grants are combinational, so they must be forced off while reset is asserted.
        if (!resetb) begin
            c_gnt = 1'b0;
            d_gnt = 1'b0;
        end
    end

    always_comb begin
        bus.dm_we     = 1'b0;
        bus.dm_addr   = '0;
        bus.dm_di     = '0;
        bus.dm_be     = '0;
        bus.dm_signed = 1'b0;
        if (c_gnt) begin
            bus.dm_we     = bus.c_we;
            bus.dm_addr   = bus.c_addr;
            bus.dm_di     = bus.c_wdata;
            bus.dm_be     = bus.c_be;
            bus.dm_signed = bus.c_signed;
        end else if (d_gnt) begin
            bus.dm_we     = bus.d_we;
            bus.dm_addr   = bus.d_addr;
            bus.dm_di     = bus.d_wdata;
            bus.dm_be     = bus.d_be;
            bus.dm_signed = bus.d_signed;
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (!resetb) begin
            state    <= ARB;
            wait_cnt <= '0;
            rd_owner <= OWN_NONE;
            halt_ack <= 1'b0;
        end else begin
            state    <= state_nxt;
            halt_ack <= (state_nxt == HALT);

            if (state == ARB && bus.d_req && !d_gnt) begin
                wait_cnt <= d_starved ? wait_cnt : wait_cnt + WAIT_W'(1);
            end else begin
                wait_cnt <= '0;
            end

            if (c_gnt && !bus.c_we) begin
                rd_owner <= OWN_C;
            end else if (d_gnt && !bus.d_we) begin
                rd_owner <= OWN_D;
            end else begin
                rd_owner <= OWN_NONE;
            end
        end
    end

    assign bus.c_gnt        = c_gnt;
    assign bus.d_gnt        = d_gnt;
    assign bus.c_rvalid     = (rd_owner == OWN_C);
    assign bus.d_rvalid     = (rd_owner == OWN_D);
    assign bus.c_rdata      = bus.dm_do;
    assign bus.d_rdata      = bus.dm_do;
    assign bus.dbg_halt_ack = halt_ack;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: MMU memory model, directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a behavioural model.
module tb_dmem_port_arbiter;
    localparam int MAX_WAIT = 4;

    logic clk = 1'b0;
    logic resetb = 1'b0;
    int   errors = 0;
    int   checks = 0;

    dmem_port_arbiter_if bus ();

    dmem_port_arbiter #(.MAX_WAIT(MAX_WAIT), .WAIT_W(3)) dut (
        .clk    (clk),
        .resetb (resetb),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- memory helpers (shared by MMU model and reference model)
    logic [31:0] mmu_mem [int unsigned];
    logic [31:0] ref_mem [int unsigned];

    function automatic logic [31:0] init_word(input int unsigned k);
        return (k * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    function automatic int unsigned word_key(input logic [31:0] a);
        return {2'b00, a[31:2]};
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] w, input logic [3:0] be, input logic sgn);
        logic [15:0] h;
        logic [7:0]  b;
        h = (be == 4'b1100) ? w[31:16] : w[15:0];
        case (be)
            4'b0010: b = w[15:8];
            4'b0100: b = w[23:16];
            4'b1000: b = w[31:24];
            default: b = w[7:0];
        endcase
        if (be == 4'b1111) return w;
        if (be == 4'b0011 || be == 4'b1100) return sgn ? {{16{h[15]}}, h} : {16'h0, h};
        return sgn ? {{24{b[7]}}, b} : {24'h0, b};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] r;
        r = w;
        case (be)
            4'b1111: r = d;
            4'b0011: r[15:0]  = d[15:0];
            4'b1100: r[31:16] = d[15:0];
            4'b0001: r[7:0]   = d[7:0];
            4'b0010: r[15:8]  = d[7:0];
            4'b0100: r[23:16] = d[7:0];
            4'b1000: r[31:24] = d[7:0];
            default: r = w;
        endcase
        return r;
    endfunction

    // ---------------- MMU: one access per enabled cycle, read data one cycle later
    int unsigned mmu_k;
    logic [31:0] mmu_w;
    always @(posedge clk) begin
        if (bus.dm_be != 4'b0000) begin
            mmu_k = word_key(bus.dm_addr);
            mmu_w = mmu_mem.exists(mmu_k) ? mmu_mem[mmu_k] : init_word(mmu_k);
            if (bus.dm_we) mmu_mem[mmu_k] = merge(mmu_w, bus.dm_di, bus.dm_be);
            else           bus.dm_do <= extract(mmu_w, bus.dm_be, bus.dm_signed);
        end
    end

    // ---------------- behavioural reference model
    // halt_run counts consecutive edges that sampled dbg_halt high: 0 arbitrate, 1 drain, 2+ halted.
    int          halt_run = 0;
    int          denied   = 0;
    int          owner    = 0;   // 0 none, 1 core, 2 debug
    logic [31:0] pend_rdata = '0;

    task automatic model_cycle();
        bit          eg_c, eg_d;
        logic        e_we, e_sgn;
        logic [31:0] e_addr, e_di;
        logic [3:0]  e_be;
        int unsigned k;
        logic [31:0] w;
        if (!resetb) begin
            check("rst_c_gnt",  32'(bus.c_gnt), 0);
            check("rst_d_gnt",  32'(bus.d_gnt), 0);
            check("rst_c_rvld", 32'(bus.c_rvalid), 0);
            check("rst_d_rvld", 32'(bus.d_rvalid), 0);
            check("rst_ack",    32'(bus.dbg_halt_ack), 0);
            check("rst_dm_we",  32'(bus.dm_we), 0);
            check("rst_dm_be",  32'(bus.dm_be), 0);
            halt_run = 0;
            denied   = 0;
            owner    = 0;
            return;
        end
        check("ack",      32'(bus.dbg_halt_ack), 32'(halt_run >= 2));
        check("c_rvalid", 32'(bus.c_rvalid), 32'(owner == 1));
        check("d_rvalid", 32'(bus.d_rvalid), 32'(owner == 2));
        if (owner == 1) check("c_rdata", bus.c_rdata, pend_rdata);
        if (owner == 2) check("d_rdata", bus.d_rdata, pend_rdata);

        eg_c = 1'b0;
        eg_d = 1'b0;
        if (halt_run == 0) begin
            eg_d = bus.d_req && (!bus.c_req || denied == MAX_WAIT);
            eg_c = bus.c_req && !eg_d;
        end else if (halt_run >= 2) begin
            eg_d = bus.d_req;
        end
        check("c_gnt", 32'(bus.c_gnt), 32'(eg_c));
        check("d_gnt", 32'(bus.d_gnt), 32'(eg_d));

        {e_we, e_addr, e_di, e_be, e_sgn} = '0;
        if (eg_c) {e_we, e_addr, e_di, e_be, e_sgn} = {bus.c_we, bus.c_addr, bus.c_wdata, bus.c_be, bus.c_signed};
        if (eg_d) {e_we, e_addr, e_di, e_be, e_sgn} = {bus.d_we, bus.d_addr, bus.d_wdata, bus.d_be, bus.d_signed};
        check("dm_we",   32'(bus.dm_we), 32'(e_we));
        check("dm_be",   32'(bus.dm_be), 32'(e_be));
        check("dm_addr", bus.dm_addr, e_addr);
        check("dm_di",   bus.dm_di, e_di);
        if (eg_c || eg_d) check("dm_signed", 32'(bus.dm_signed), 32'(e_sgn));

        if (eg_c || eg_d) begin
            k = word_key(e_addr);
            w = ref_mem.exists(k) ? ref_mem[k] : init_word(k);
            if (e_we) ref_mem[k] = merge(w, e_di, e_be);
            else      pend_rdata = extract(w, e_be, e_sgn);
        end
        owner    = (eg_c && !bus.c_we) ? 1 : (eg_d && !bus.d_we) ? 2 : 0;
        denied   = (halt_run == 0 && bus.d_req && !eg_d) ? ((denied < MAX_WAIT) ? denied + 1 : MAX_WAIT) : 0;
        halt_run = bus.dbg_halt ? ((halt_run < 2) ? halt_run + 1 : 2) : 0;
    endtask

    always @(negedge clk) begin
        #1;
        model_cycle();
    end

    // ---------------- stimulus
    task automatic set_c(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be, input logic s);
        {bus.c_req, bus.c_we, bus.c_addr, bus.c_wdata, bus.c_be, bus.c_signed} = {1'b1, we, a, d, be, s};
    endtask

    task automatic set_d(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be, input logic s);
        {bus.d_req, bus.d_we, bus.d_addr, bus.d_wdata, bus.d_be, bus.d_signed} = {1'b1, we, a, d, be, s};
    endtask

    function automatic logic [3:0] rand_be();
        logic [3:0] tab [7] = '{4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8};
        return tab[$urandom_range(0, 6)];
    endfunction

    function automatic logic [31:0] rand_addr(input logic [3:0] be);
        logic [31:0] off;
        case (be)
            4'h2:       off = 1;
            4'h4, 4'hC: off = 2;
            4'h8:       off = 3;
            default:    off = 0;
        endcase
        return 32'h1000_0000 + 32'($urandom_range(0, 15)) * 4 + off;
    endfunction

    logic [9:0] c_pat, d_pat;
    logic [3:0] rb;
    bit         c_seen, d_seen;

    initial begin
        mmu_mem[word_key(32'h1000_0000)] = 32'h8011_2233;
        ref_mem[word_key(32'h1000_0000)] = 32'h8011_2233;
        mmu_mem[word_key(32'h1000_0010)] = 32'hCAFE_F00D;
        ref_mem[word_key(32'h1000_0010)] = 32'hCAFE_F00D;
        {bus.c_req, bus.c_we, bus.c_addr, bus.c_wdata, bus.c_be, bus.c_signed} = '0;
        {bus.d_req, bus.d_we, bus.d_addr, bus.d_wdata, bus.d_be, bus.d_signed} = '0;
        bus.dbg_halt = 1'b0;

        // Request held during reset must not be granted.
        set_c(1'b1, 32'h1000_0020, 32'h1, 4'hF, 1'b0);
        @(negedge clk); #2;
        check("t0_rst_c_gnt", 32'(bus.c_gnt), 0);
        check("t0_rst_dm_be", 32'(bus.dm_be), 0);
        @(negedge clk);
        bus.c_req = 1'b0;
        resetb = 1'b1;
        #2 check("t0_ack", 32'(bus.dbg_halt_ack), 0);

        // 1: lone core read.
        @(negedge clk);
        set_c(1'b0, 32'h1000_0010, 32'h0, 4'hF, 1'b0);
        #2 check("t1_c_gnt", 32'(bus.c_gnt), 1);
        check("t1_dm_addr", bus.dm_addr, 32'h1000_0010);
        @(negedge clk);
        bus.c_req = 1'b0;
        #2 check("t1_c_rvalid", 32'(bus.c_rvalid), 1);
        check("t1_c_rdata", bus.c_rdata, 32'hCAFE_F00D);
        check("t1_d_rvalid", 32'(bus.d_rvalid), 0);

        // 2: both request continuously; D wins every fifth cycle.
        @(negedge clk);
        set_c(1'b0, 32'h1000_0014, 32'h0, 4'hF, 1'b0);
        set_d(1'b0, 32'h1000_0018, 32'h0, 4'hF, 1'b0);
        for (int i = 0; i < 10; i++) begin
            if (i != 0) @(negedge clk);
            #2;
            c_pat[i] = bus.c_gnt;
            d_pat[i] = bus.d_gnt;
        end
        check("t2_d_pattern", 32'(d_pat), 32'(10'b10_0001_0000));
        check("t2_c_pattern", 32'(c_pat), 32'(10'b01_1110_1111));
        @(negedge clk);
        bus.c_req = 1'b0;
        bus.d_req = 1'b0;

        // 3: signed byte load by C then D read, back to back.
        @(negedge clk);
        set_c(1'b0, 32'h1000_0003, 32'h0, 4'h8, 1'b1);
        set_d(1'b0, 32'h1000_0010, 32'h0, 4'hF, 1'b0);
        #2 check("t3_c_gnt", 32'(bus.c_gnt), 1);
        @(negedge clk);
        bus.c_req = 1'b0;
        #2 check("t3_d_gnt", 32'(bus.d_gnt), 1);
        check("t3_c_rdata", bus.c_rdata, 32'hFFFF_FF80);
        check("t3_d_rvalid_early", 32'(bus.d_rvalid), 0);
        @(negedge clk);
        bus.d_req = 1'b0;
        #2 check("t3_d_rvalid", 32'(bus.d_rvalid), 1);
        check("t3_c_rvalid", 32'(bus.c_rvalid), 0);
        check("t3_d_rdata", bus.d_rdata, 32'hCAFE_F00D);

        // 4: halt rises with a core read grant; D writes exclusively.
        @(negedge clk);
        set_c(1'b0, 32'h1000_0010, 32'h0, 4'hF, 1'b0);
        bus.dbg_halt = 1'b1;
        #2 check("t4_c_gnt", 32'(bus.c_gnt), 1);
        @(negedge clk);
        set_c(1'b0, 32'h1000_0014, 32'h0, 4'hF, 1'b0);
        #2 check("t4_drain_c_rvalid", 32'(bus.c_rvalid), 1);
        check("t4_drain_c_gnt", 32'(bus.c_gnt), 0);
        check("t4_drain_ack", 32'(bus.dbg_halt_ack), 0);
        @(negedge clk);
        set_d(1'b1, 32'h8000_0004, 32'h1234_5678, 4'hF, 1'b0);
        #2 check("t4_ack", 32'(bus.dbg_halt_ack), 1);
        check("t4_d_gnt", 32'(bus.d_gnt), 1);
        check("t4_c_held", 32'(bus.c_gnt), 0);
        check("t4_dm_addr", bus.dm_addr, 32'h8000_0004);
        check("t4_dm_be", 32'(bus.dm_be), 32'hF);
        check("t4_dm_we", 32'(bus.dm_we), 1);
        @(negedge clk);
        bus.d_req = 1'b0;
        #2 check("t4_c_held2", 32'(bus.c_gnt), 0);

        // 5: halt falls; ARB next cycle grants the pending core request.
        @(negedge clk);
        bus.dbg_halt = 1'b0;
        #2 check("t5_c_gnt_halt", 32'(bus.c_gnt), 0);
        check("t5_ack_halt", 32'(bus.dbg_halt_ack), 1);
        @(negedge clk);
        #2 check("t5_c_gnt", 32'(bus.c_gnt), 1);
        check("t5_ack", 32'(bus.dbg_halt_ack), 0);

        // 6: reset in HALT with a read return pending.
        @(negedge clk);
        bus.c_req = 1'b0;
        bus.dbg_halt = 1'b1;
        @(negedge clk);
        @(negedge clk);
        set_d(1'b0, 32'h1000_0010, 32'h0, 4'hF, 1'b0);
        #2 check("t6_d_gnt", 32'(bus.d_gnt), 1);
        @(negedge clk);
        resetb = 1'b0;
        #2 check("t6_d_rvalid", 32'(bus.d_rvalid), 0);
        check("t6_ack", 32'(bus.dbg_halt_ack), 0);
        check("t6_d_gnt_rst", 32'(bus.d_gnt), 0);
        @(negedge clk);
        resetb = 1'b1;
        bus.dbg_halt = 1'b0;
        bus.d_req = 1'b0;
        set_c(1'b0, 32'h1000_0010, 32'h0, 4'hF, 1'b0);
        #2 check("t6_arb_c_gnt", 32'(bus.c_gnt), 1);
        @(negedge clk);
        bus.c_req = 1'b0;
        resetb = 1'b0;
        #2 check("t6_c_rvalid", 32'(bus.c_rvalid), 0);
        @(negedge clk);
        resetb = 1'b1;

        // Randomized traffic; requests are held until granted.
        c_seen = 1'b0;
        d_seen = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (!(bus.c_req && !c_seen)) begin
                if ($urandom_range(0, 3) != 0) begin
                    rb = rand_be();
                    set_c(1'($urandom_range(0, 1)), rand_addr(rb), $urandom, rb, 1'($urandom_range(0, 1)));
                end else begin
                    bus.c_req = 1'b0;
                end
            end
            if (!(bus.d_req && !d_seen)) begin
                if ($urandom_range(0, 1) != 0) begin
                    rb = rand_be();
                    set_d(1'($urandom_range(0, 1)), rand_addr(rb), $urandom, rb, 1'($urandom_range(0, 1)));
                end else begin
                    bus.d_req = 1'b0;
                end
            end
            if ($urandom_range(0, 15) == 0) bus.dbg_halt = ~bus.dbg_halt;
            resetb = ($urandom_range(0, 399) != 0);
            #2;
            c_seen = bus.c_gnt;
            d_seen = bus.d_gnt;
        end

        @(negedge clk);
        resetb = 1'b1;
        bus.c_req = 1'b0;
        bus.d_req = 1'b0;
        bus.dbg_halt = 1'b0;
        repeat (4) @(negedge clk);
        #3;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
